md_issue_ctrl: RTL and testbench
================================

# md_issue_ctrl

Issue-side controller for the multiply/divide unit. It sits between the D and E pipeline stages and decodes each instruction's mult/div class. It drives the unit's `Start`/`MDOp` from E, mirrors the unit's countdown, and stalls D while a HI/LO-touching instruction would collide with an in-flight operation. It also steers mfhi/mflo reads in E.

## Interface
- `MULT_LAT`, default 5: cycles the unit stays busy after accepting mult/multu.
- `DIV_LAT`, default 10: cycles the unit stays busy after accepting div/divu.
- `CNT_W`, default 4: mirror counter width; must hold `max(MULT_LAT, DIV_LAT)`.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous, active-high.
- `md_cls_d`  in  4: D-stage class. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo. Values 9-15 are treated as none.
- `hold`  in  1: stall from other hazard sources. D frozen, E receives a bubble.
- `Req`  in  1: interrupt/exception flush of E this cycle.
- `Busy`  in  1: busy flag from the unit; used only by the checker (see Configuration).
- `Start`  out  1: start pulse to the unit.
- `MDOp`  out  3: op to the unit. 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo.
- `stall_md`  out  1: freeze D/F, bubble into E.
- `hilo_rd`  out  1: E holds mfhi/mflo (write-back from the HI/LO mux).
- `hilo_sel`  out  1: 1 selects HI, 0 selects LO; valid when `hilo_rd` is 1.
- `md_err`  out  1: sticky mirror/unit mismatch flag.

## Operation
- E register `cls_e` (4 bits) updates every cycle: NONE if `stall_md | hold | Req`, otherwise `md_cls_d`.
- Combinational outputs from `cls_e`:
  - `Start` = `cls_e` in 1..4.
  - `MDOp` = `cls_e` for classes 1..6, else 0.
  - `hilo_rd` = `cls_e` in {7, 8}.
  - `hilo_sel` = (`cls_e` == 7).
- `Start` and `MDOp` are driven regardless of `Req`. The unit itself ignores `Start` while `Req` is high.
- Accept = `Start & ~Req & (cnt == 0)`.
- Mirror counter `cnt`:
  - On accept, load `MULT_LAT` (classes 1, 2) or `DIV_LAT` (classes 3, 4).
  - Otherwise, if `cnt != 0`, decrement.
  - `pending` = (`cnt != 0`).
- `stall_md` = (`md_cls_d` in 1..8) & (`Start` | `pending`). Non-md instructions never stall here.
- Mid-operation flush: `Req` while `pending` does not clear `cnt`, because the unit does not abort. Stalling continues until `cnt` reaches 0.
- Simultaneous `Req` and `Start`:
  - The start is dropped: `cnt` stays 0 and `cls_e` becomes NONE next cycle.
  - A D-stage md instruction is still stalled that cycle, because `Start` = 1.
- Reset (async): `cls_e` = 0, `cnt` = 0, `md_err` = 0. Resulting outputs: `Start` = 0, `MDOp` = 0, `stall_md` = 0, `hilo_rd` = 0, `hilo_sel` = 0.

## Timing
- Latency from D to E: one cycle when not stalled.
- Accept at edge t: `pending` is high for cycles t+1..t+LAT. The unit writes HI/LO at edge t+LAT, exactly when `cnt` returns to 0.
- A dependent mfhi/mflo/mthi/mtlo/mult/div waiting in D is released in the cycle after `cnt` reaches 0. It enters E at the next edge, and mfhi/mflo read the new HI/LO there.
- Back-to-back mult followed by mult (D directly behind E): the second instruction stalls for 1 + `MULT_LAT` cycles.
- `stall_md` is purely combinational from `md_cls_d`, `cls_e` and `cnt`. It has no dependence on `Busy`, so there is no timing path from the unit.

## Configuration
- `MD_BUSY_CHECK_EN`, when defined:
  - A one-bit `armed` register is set on the first accept and cleared by `rst`.
  - While `armed`, any cycle where `Busy != pending` sets `md_err`, which stays set until `rst`.
- When not defined: `md_err` is tied to 0, `Busy` is unused, and no `armed` register exists.

## Test plan
- Reset, then mult in D: E `Start` = 1 and `MDOp` = 1. `pending` is high for 5 cycles. A following mflo in D has `stall_md` = 1 for 6 cycles, then enters E with `hilo_rd` = 1 and `hilo_sel` = 0.
- divu then mfhi: `MDOp` = 4, stall lasts 11 cycles, then `hilo_sel` = 1.
- `Req` = 1 in the cycle mult is in E: `cnt` stays 0 and the next md instruction in D stalls only that one cycle.
- `Req` asserted 3 cycles into a div: `cnt` keeps counting to 0, and mthi in D stays stalled until then.
- `hold` = 1 with mult in D: `cls_e` = 0 and `Start` = 0. When `hold` drops, mult enters E and starts.
- `MD_BUSY_CHECK_EN` defined, `Busy` forced low 2 cycles after a mult accept: `md_err` = 1 and stays 1 until `rst`.

Source files
------------

// File: rtl/md_issue_ctrl_if.sv
// D/E-side signal bundle between the pipeline and the mult/div issue controller.
// master = the issue controller, slave = the pipeline/unit environment driving it.
interface md_issue_ctrl_if;
    logic [3:0] md_cls_d;
    logic       hold;
    logic       Req;
    logic       Busy;
    logic       Start;
    logic [2:0] MDOp;
    logic       stall_md;
    logic       hilo_rd;
    logic       hilo_sel;
    logic       md_err;

    modport master (
        input  md_cls_d, hold, Req, Busy,
        output Start, MDOp, stall_md, hilo_rd, hilo_sel, md_err
    );

    modport slave (
        output md_cls_d, hold, Req, Busy,
        input  Start, MDOp, stall_md, hilo_rd, hilo_sel, md_err
    );
endinterface

// File: rtl/md_issue_ctrl.sv
// Mult/div issue control: E-stage class register, busy-countdown mirror, D-stage HI/LO hazard stall.
// Optional MD_BUSY_CHECK_EN adds a sticky mirror-vs-unit Busy mismatch flag on md_err.
module md_issue_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10,
    parameter int CNT_W    = 4
) (
    input  logic           clk,
    input  logic           rst,
    md_issue_ctrl_if.master md
);

    localparam logic [3:0] CLS_NONE  = 4'd0;
    localparam logic [3:0] CLS_MULTU = 4'd2;
    localparam logic [3:0] CLS_DIVU  = 4'd4;
    localparam logic [3:0] CLS_MTLO  = 4'd6;
    localparam logic [3:0] CLS_MFHI  = 4'd7;
    localparam logic [3:0] CLS_MFLO  = 4'd8;

    localparam logic [CNT_W-1:0] LAT_MULT = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] LAT_DIV  = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       r_cls_e;
    logic [CNT_W-1:0] r_cnt;

    logic             w_pending;
    logic             w_start;
    logic             w_accept;
    logic             w_d_is_md;
    logic             w_stall;
    logic [3:0]       w_cls_d_norm;
    logic [3:0]       w_cls_e_nxt;
    logic [CNT_W-1:0] w_lat;

    assign w_pending    = (r_cnt != '0);
    assign w_start      = (r_cls_e != CLS_NONE) && (r_cls_e <= CLS_DIVU);
    assign w_accept     = w_start && !md.Req && !w_pending;
    assign w_d_is_md    = (md.md_cls_d != CLS_NONE) && (md.md_cls_d <= CLS_MFLO);
    // Start counts as busy too: the unit takes the op at this edge, so D must not slip past it.
    assign w_stall      = w_d_is_md && (w_start || w_pending);
    assign w_cls_d_norm = (md.md_cls_d <= CLS_MFLO) ? md.md_cls_d : CLS_NONE;
    assign w_cls_e_nxt  = (w_stall || md.hold || md.Req) ? CLS_NONE : w_cls_d_norm;
    assign w_lat        = (r_cls_e <= CLS_MULTU) ? LAT_MULT : LAT_DIV;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cls_e <= CLS_NONE;
            r_cnt   <= '0;
        end else begin
            r_cls_e <= w_cls_e_nxt;
            // A flush never clears the mirror: the unit runs the op to completion regardless.
            if (w_accept) begin
                r_cnt <= w_lat;
            end else if (w_pending) begin
                r_cnt <= r_cnt - CNT_ONE;
            end
        end
    end

    assign md.Start    = w_start;
    assign md.MDOp     = ((r_cls_e != CLS_NONE) && (r_cls_e <= CLS_MTLO)) ? r_cls_e[2:0] : 3'd0;
    assign md.stall_md = w_stall;
    assign md.hilo_rd  = (r_cls_e == CLS_MFHI) || (r_cls_e == CLS_MFLO);
    assign md.hilo_sel = (r_cls_e == CLS_MFHI);

`ifdef MD_BUSY_CHECK_EN
    logic r_armed;
    logic r_md_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed  <= 1'b0;
            r_md_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_armed <= 1'b1;
            end
            if (r_armed && (md.Busy != w_pending)) begin
                r_md_err <= 1'b1;
            end
        end
    end

    assign md.md_err = r_md_err;
`else
    logic w_unused_busy;
    assign w_unused_busy = md.Busy;
    assign md.md_err     = 1'b0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: directed scenario tasks plus a randomized run against a time-based reference model.
module tb_md_issue_ctrl;
    localparam int ML = 5;
    localparam int DL = 10;

    logic clk;
    logic rst;
    md_issue_ctrl_if bus ();

    md_issue_ctrl #(.MULT_LAT(ML), .DIV_LAT(DL), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .md  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: E class, plus the edge number of the last accept and its latency.
    int m_cls;
    int m_acc_edge;
    int m_lat;
    int cyc;
    bit m_err;
    bit m_armed;
    bit busy_force;
    bit busy_val;

    function automatic bit f_pending();
        return (cyc >= m_acc_edge) && (cyc < m_acc_edge + m_lat);
    endfunction
    function automatic bit f_start();
        return (m_cls >= 1) && (m_cls <= 4);
    endfunction
    function automatic int f_mdop();
        return ((m_cls >= 1) && (m_cls <= 6)) ? m_cls : 0;
    endfunction
    function automatic bit f_hrd();
        return (m_cls == 7) || (m_cls == 8);
    endfunction
    function automatic bit f_hsel();
        return m_cls == 7;
    endfunction
    function automatic bit f_stall(input int d);
        return (d >= 1) && (d <= 8) && (f_start() || f_pending());
    endfunction

    task automatic model_reset();
        m_cls      = 0;
        m_acc_edge = -1000;
        m_lat      = 0;
        m_err      = 1'b0;
        m_armed    = 1'b0;
    endtask

    task automatic drive(input int d, input bit h, input bit r);
        bus.md_cls_d = 4'(d);
        bus.hold     = h;
        bus.Req      = r;
        bus.Busy     = busy_force ? busy_val : f_pending();
        #1;
    endtask

    task automatic step();
        int d;
        bit st;
        bit acc;
        d   = int'(bus.md_cls_d);
        st  = f_stall(d);
        acc = f_start() && !bus.Req && !f_pending();
`ifdef MD_BUSY_CHECK_EN
        if (m_armed && (bus.Busy != f_pending())) m_err = 1'b1;
        if (acc) m_armed = 1'b1;
`endif
        if (acc) begin
            m_acc_edge = cyc + 1;
            m_lat      = (m_cls <= 2) ? ML : DL;
        end
        m_cls = (st || bus.hold || bus.Req || d > 8) ? 0 : d;
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle();
        int k;
        k = 0;
        drive(0, 0, 0);
        while ((f_pending() || m_cls != 0) && k < 20) begin
            step();
            drive(0, 0, 0);
            k++;
        end
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        busy_force = 1'b0;
        model_reset();
        drive(0, 0, 0);
        #2;
        n_chk++; if (bus.Start !== 1'b0)    begin n_bad++; $display("FAIL reset_start got=%b exp=0", bus.Start); end
        n_chk++; if (bus.MDOp !== 3'd0)     begin n_bad++; $display("FAIL reset_mdop got=%0d exp=0", bus.MDOp); end
        n_chk++; if (bus.stall_md !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b exp=0", bus.stall_md); end
        n_chk++; if (bus.hilo_rd !== 1'b0)  begin n_bad++; $display("FAIL reset_hilo_rd got=%b exp=0", bus.hilo_rd); end
        n_chk++; if (bus.hilo_sel !== 1'b0) begin n_bad++; $display("FAIL reset_hilo_sel got=%b exp=0", bus.hilo_sel); end
        n_chk++; if (bus.md_err !== 1'b0)   begin n_bad++; $display("FAIL reset_md_err got=%b exp=0", bus.md_err); end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // Issue op in D, then hold dep in D behind it; count stall cycles until dep is released.
    task automatic issue_and_wait(input int op, input int dep, input int req_at, output int n);
        drive(op, 0, 0);
        step();
        n = 0;
        drive(dep, 0, 0);
        while (bus.stall_md === 1'b1 && n < 40) begin
            n++;
            step();
            drive(dep, 0, (n == req_at));
        end
    endtask

    task automatic test_mult_mflo();
        int n;
        drive(1, 0, 0);
        step();
        n_chk++; if (bus.Start !== 1'b1) begin n_bad++; $display("FAIL mult_start got=%b exp=1", bus.Start); end
        n_chk++; if (bus.MDOp !== 3'd1)  begin n_bad++; $display("FAIL mult_mdop got=%0d exp=1", bus.MDOp); end
        n = 0;
        drive(8, 0, 0);
        while (bus.stall_md === 1'b1 && n < 40) begin
            n++;
            step();
            drive(8, 0, 0);
        end
        n_chk++; if (n != 1 + ML) begin n_bad++; $display("FAIL mflo_stall_len got=%0d exp=%0d", n, 1 + ML); end
        step();
        drive(0, 0, 0);
        n_chk++; if (bus.hilo_rd !== 1'b1)  begin n_bad++; $display("FAIL mflo_hilo_rd got=%b exp=1", bus.hilo_rd); end
        n_chk++; if (bus.hilo_sel !== 1'b0) begin n_bad++; $display("FAIL mflo_hilo_sel got=%b exp=0", bus.hilo_sel); end
        idle();
    endtask

    task automatic test_divu_mfhi();
        int n;
        drive(4, 0, 0);
        step();
        n_chk++; if (bus.MDOp !== 3'd4) begin n_bad++; $display("FAIL divu_mdop got=%0d exp=4", bus.MDOp); end
        n = 0;
        drive(7, 0, 0);
        while (bus.stall_md === 1'b1 && n < 40) begin
            n++;
            step();
            drive(7, 0, 0);
        end
        n_chk++; if (n != 1 + DL) begin n_bad++; $display("FAIL mfhi_stall_len got=%0d exp=%0d", n, 1 + DL); end
        step();
        drive(0, 0, 0);
        n_chk++; if (bus.hilo_rd !== 1'b1)  begin n_bad++; $display("FAIL mfhi_hilo_rd got=%b exp=1", bus.hilo_rd); end
        n_chk++; if (bus.hilo_sel !== 1'b1) begin n_bad++; $display("FAIL mfhi_hilo_sel got=%b exp=1", bus.hilo_sel); end
        idle();
    endtask

    task automatic test_req_start();
        drive(1, 0, 0);
        step();
        drive(2, 0, 1);
        n_chk++; if (bus.Start !== 1'b1)    begin n_bad++; $display("FAIL req_start_driven got=%b exp=1", bus.Start); end
        n_chk++; if (bus.stall_md !== 1'b1) begin n_bad++; $display("FAIL req_start_stall got=%b exp=1", bus.stall_md); end
        step();
        drive(2, 0, 0);
        n_chk++; if (bus.Start !== 1'b0)    begin n_bad++; $display("FAIL req_start_bubble got=%b exp=0", bus.Start); end
        n_chk++; if (bus.stall_md !== 1'b0) begin n_bad++; $display("FAIL req_start_release got=%b exp=0 (start dropped)", bus.stall_md); end
        step();
        drive(0, 0, 0);
        n_chk++; if (bus.MDOp !== 3'd2) begin n_bad++; $display("FAIL req_start_multu got=%0d exp=2", bus.MDOp); end
        idle();
    endtask

    task automatic test_req_mid_div();
        int n;
        issue_and_wait(3, 5, 3, n);
        n_chk++; if (n != 1 + DL) begin n_bad++; $display("FAIL req_mid_div_stall got=%0d exp=%0d", n, 1 + DL); end
        step();
        drive(0, 0, 0);
        n_chk++; if (bus.MDOp !== 3'd5) begin n_bad++; $display("FAIL mthi_mdop got=%0d exp=5", bus.MDOp); end
        n_chk++; if (bus.Start !== 1'b0) begin n_bad++; $display("FAIL mthi_start got=%b exp=0", bus.Start); end
        idle();
    endtask

    task automatic test_hold();
        drive(1, 1, 0);
        step();
        drive(1, 1, 0);
        n_chk++; if (bus.Start !== 1'b0)    begin n_bad++; $display("FAIL hold_start got=%b exp=0", bus.Start); end
        n_chk++; if (bus.MDOp !== 3'd0)     begin n_bad++; $display("FAIL hold_mdop got=%0d exp=0", bus.MDOp); end
        n_chk++; if (bus.stall_md !== 1'b0) begin n_bad++; $display("FAIL hold_stall got=%b exp=0", bus.stall_md); end
        step();
        drive(1, 0, 0);
        step();
        drive(0, 0, 0);
        n_chk++; if (bus.Start !== 1'b1) begin n_bad++; $display("FAIL hold_release_start got=%b exp=1", bus.Start); end
        n_chk++; if (bus.MDOp !== 3'd1)  begin n_bad++; $display("FAIL hold_release_mdop got=%0d exp=1", bus.MDOp); end
        idle();
    endtask

    task automatic test_back_to_back();
        int n;
        issue_and_wait(1, 2, -1, n);
        n_chk++; if (n != 1 + ML) begin n_bad++; $display("FAIL b2b_stall got=%0d exp=%0d", n, 1 + ML); end
        step();
        drive(0, 0, 0);
        n_chk++; if (bus.Start !== 1'b1) begin n_bad++; $display("FAIL b2b_second_start got=%b exp=1", bus.Start); end
        n_chk++; if (bus.MDOp !== 3'd2)  begin n_bad++; $display("FAIL b2b_second_mdop got=%0d exp=2", bus.MDOp); end
        idle();
    endtask

    task automatic test_random();
        int d;
        for (int i = 0; i < 400; i++) begin
            d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 8));
            drive(d, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
            n_chk++; if (bus.Start !== f_start())       begin n_bad++; $display("FAIL rnd_start cyc=%0d got=%b exp=%b", cyc, bus.Start, f_start()); end
            n_chk++; if (int'(bus.MDOp) != f_mdop())    begin n_bad++; $display("FAIL rnd_mdop cyc=%0d got=%0d exp=%0d", cyc, bus.MDOp, f_mdop()); end
            n_chk++; if (bus.stall_md !== f_stall(d))   begin n_bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, bus.stall_md, f_stall(d)); end
            n_chk++; if (bus.hilo_rd !== f_hrd())       begin n_bad++; $display("FAIL rnd_hilo_rd cyc=%0d got=%b exp=%b", cyc, bus.hilo_rd, f_hrd()); end
            n_chk++; if (bus.hilo_sel !== f_hsel())     begin n_bad++; $display("FAIL rnd_hilo_sel cyc=%0d got=%b exp=%b", cyc, bus.hilo_sel, f_hsel()); end
            n_chk++; if (bus.md_err !== m_err)          begin n_bad++; $display("FAIL rnd_md_err cyc=%0d got=%b exp=%b", cyc, bus.md_err, m_err); end
            step();
        end
        idle();
    endtask

    task automatic test_busy_check();
        drive(1, 0, 0);
        step();
        drive(0, 0, 0);
        step();
        drive(0, 0, 0);
        step();
        busy_force = 1'b1;
        busy_val   = 1'b0;
        drive(0, 0, 0);
        n_chk++; if (bus.md_err !== 1'b0) begin n_bad++; $display("FAIL busy_pre_err got=%b exp=0", bus.md_err); end
        for (int i = 0; i < 8; i++) begin
            step();
            drive(0, 0, 0);
            n_chk++; if (bus.md_err !== m_err) begin n_bad++; $display("FAIL busy_err_hold i=%0d got=%b exp=%b", i, bus.md_err, m_err); end
        end
`ifdef MD_BUSY_CHECK_EN
        n_chk++; if (bus.md_err !== 1'b1) begin n_bad++; $display("FAIL busy_err_set got=%b exp=1", bus.md_err); end
`endif
        busy_force = 1'b0;
        do_reset();
        n_chk++; if (bus.md_err !== 1'b0) begin n_bad++; $display("FAIL busy_err_reset got=%b exp=0", bus.md_err); end
        step();
    endtask

    initial begin
        cyc = 0;
        test_reset();
        test_mult_mflo();
        test_divu_mfhi();
        test_req_start();
        test_req_mid_div();
        test_hold();
        test_back_to_back();
        test_random();
        test_busy_check();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
